// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared direction encoding and key index map for the snake
//               direction input stage.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    // Codes are chosen so that the reverse of any direction is its bitwise NOT.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    localparam int KEY_UP_IDX    = 0;
    localparam int KEY_RIGHT_IDX = 1;
    localparam int KEY_LEFT_IDX  = 2;
    localparam int KEY_DOWN_IDX  = 3;

    localparam logic [1:0] QUEUE_DEPTH = 2'd2;

    function automatic dir_t opposite(input dir_t d);
        return dir_t'(~d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_dir_input_if.sv
`default_nettype none
// ============================================================================
// Module      : snake_dir_input_if
// Description : Button, strobe and direction-status bundle between the game
//               top level and the direction input stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface snake_dir_input_if;

    logic [3:0] KEY;
    logic       tick;
    logic       clear;
    logic [1:0] dir;
    logic       dir_changed;
    logic [1:0] q_count;
    logic       overflow;
    logic [3:0] key_level;

    modport master (
        output KEY, tick, clear,
        input  dir, dir_changed, q_count, overflow, key_level
    );

    modport slave (
        input  KEY, tick, clear,
        output dir, dir_changed, q_count, overflow, key_level
    );

endinterface
`default_nettype wire

// File: rtl/snake_dir_input_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchroniser, stable-level debouncer and press strobe
//               for one active-low push button.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  wire logic CLOCK_50,
    input  wire logic rst_n,
    input  wire logic key_n_i,
    output logic      level_o,
    output logic      press_o
);

    localparam int          CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // stable_q is kept active-low like the raw button, so reset means released.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == C_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = stable_q & ~stable_d;
    assign level_o = ~stable_q;

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/snake_dir_input.sv
`default_nettype none
// ============================================================================
// Module      : snake_dir_input
// Description : Debounced button input, turn legality filter and two-entry
//               turn queue that is drained one entry per game tick.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_dir_input
    import snake_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [1:0] INIT_DIR        = 2'd2
) (
    input  wire logic          CLOCK_50,
    input  wire logic          rst_n,
    snake_dir_input_if.slave   bus
);

    logic [3:0] press_w;
    logic [3:0] level_w;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .CLOCK_50 (CLOCK_50),
                .rst_n    (rst_n),
                .key_n_i  (bus.KEY[g]),
                .level_o  (level_w[g]),
                .press_o  (press_w[g])
            );
        end
    endgenerate

    dir_t       dir_q, dir_d;
    dir_t       q0_q, q0_d;
    dir_t       q1_q, q1_d;
    logic [1:0] cnt_q, cnt_d;
    logic       chg_q, chg_d;
    logic       ovf_q, ovf_d;

    logic       press_valid_w;
    dir_t       press_dir_w;
    dir_t       ref_dir_w;
    logic       legal_w;

    always_comb begin
        press_valid_w = 1'b1;
        press_dir_w   = DIR_UP;
        if (press_w[KEY_UP_IDX]) begin
            press_dir_w = DIR_UP;
        end else if (press_w[KEY_LEFT_IDX]) begin
            press_dir_w = DIR_LEFT;
        end else if (press_w[KEY_RIGHT_IDX]) begin
            press_dir_w = DIR_RIGHT;
        end else if (press_w[KEY_DOWN_IDX]) begin
            press_dir_w = DIR_DOWN;
        end else begin
            press_valid_w = 1'b0;
        end
    end

    // A press is judged against the direction the snake will have once
    // everything already queued has been applied.
    assign ref_dir_w = (cnt_q == 2'd0) ? dir_q :
                       (cnt_q == QUEUE_DEPTH) ? q1_q : q0_q;
    assign legal_w   = press_valid_w && (press_dir_w != ref_dir_w) &&
                       (press_dir_w != opposite(ref_dir_w));

    always_comb begin
        dir_d = dir_q;
        q0_d  = q0_q;
        q1_d  = q1_q;
        cnt_d = cnt_q;
        chg_d = 1'b0;
        ovf_d = 1'b0;
        if (bus.clear) begin
            cnt_d = 2'd0;
            dir_d = dir_t'(INIT_DIR);
        end else begin
            if (bus.tick && (cnt_q != 2'd0)) begin
                dir_d = q0_q;
                chg_d = 1'b1;
                q0_d  = q1_q;
                cnt_d = cnt_q - 2'd1;
            end
            // Occupancy after the pop decides whether the push fits.
            if (legal_w) begin
                if (cnt_d == QUEUE_DEPTH) begin
                    ovf_d = 1'b1;
                end else begin
                    if (cnt_d == 2'd0) begin
                        q0_d = press_dir_w;
                    end else begin
                        q1_d = press_dir_w;
                    end
                    cnt_d = cnt_d + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            dir_q <= dir_t'(INIT_DIR);
            q0_q  <= DIR_UP;
            q1_q  <= DIR_UP;
            cnt_q <= 2'd0;
            chg_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
            q0_q  <= q0_d;
            q1_q  <= q1_d;
            cnt_q <= cnt_d;
            chg_q <= chg_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.dir         = dir_q;
    assign bus.q_count     = cnt_q;
    assign bus.dir_changed = chg_q;
    assign bus.overflow    = ovf_q;
    assign bus.key_level   = level_w;

endmodule
`default_nettype wire

// File: tb/tb_snake_dir_input.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_dir_input
// Description : Directed and randomised bench for snake_dir_input, checked
//               every cycle against a behavioural model of the button rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_dir_input;

    localparam int         D    = 4;
    localparam logic [1:0] INIT = 2'd2;

    logic CLOCK_50 = 1'b0;
    logic rst_n    = 1'b0;

    snake_dir_input_if bus();

    snake_dir_input #(
        .DEBOUNCE_CYCLES(D),
        .INIT_DIR       (INIT)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int tests = 0;
    int fails = 0;
    string phase = "init";

    // Key index -> direction code, and key indices in press priority order.
    int key2dir [4] = '{0, 2, 1, 3};
    int prio    [4] = '{0, 2, 1, 3};

    int         m_dir;
    int         m_q[$];
    bit   [3:0] m_level;
    int         m_run [4];
    logic [3:0] hist[$];
    bit         m_chg, m_ovf;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s: observed %0h, expected %0h", phase, tag, obs, exp);
        end
    endtask

    // One rising edge of the reference behaviour, using the inputs now applied.
    task automatic model_edge();
        logic [3:0] synced;
        bit   [3:0] press;
        int p, r;
        if (!rst_n) begin
            m_dir = INIT;
            m_q.delete();
            m_chg = 0;
            m_ovf = 0;
            m_level = '0;
            for (int k = 0; k < 4; k++) m_run[k] = 0;
            hist.delete();
            hist.push_back(4'hF);
            hist.push_back(4'hF);
            return;
        end
        synced = (hist.size() >= 2) ? hist[hist.size()-2] : 4'hF;
        press  = '0;
        for (int k = 0; k < 4; k++) begin
            if ((!synced[k]) != m_level[k]) begin
                m_run[k]++;
                if (m_run[k] == D) begin
                    m_level[k] = !m_level[k];
                    m_run[k]   = 0;
                    press[k]   = m_level[k];
                end
            end else begin
                m_run[k] = 0;
            end
        end
        hist.push_back(bus.KEY);
        if (hist.size() > 3) void'(hist.pop_front());
        m_chg = 0;
        m_ovf = 0;
        if (bus.clear) begin
            m_q.delete();
            m_dir = INIT;
        end else begin
            p = -1;
            for (int i = 0; i < 4; i++)
                if (p < 0 && press[prio[i]]) p = key2dir[prio[i]];
            r = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
            if (bus.tick && m_q.size() > 0) begin
                m_dir = m_q.pop_front();
                m_chg = 1;
            end
            if (p >= 0 && p != r && p != 3 - r) begin
                if (m_q.size() < 2) m_q.push_back(p);
                else                m_ovf = 1;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CLOCK_50);
        #1;
        check("dir",         {6'd0, bus.dir},         8'(m_dir));
        check("q_count",     {6'd0, bus.q_count},     8'(m_q.size()));
        check("dir_changed", {7'd0, bus.dir_changed}, {7'd0, m_chg});
        check("overflow",    {7'd0, bus.overflow},    {7'd0, m_ovf});
        check("key_level",   {4'd0, bus.key_level},   {4'd0, m_level});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press_key(input int k, input int hold);
        bus.KEY[k] = 1'b0;
        cycles(hold);
        bus.KEY[k] = 1'b1;
        cycles(8);
    endtask

    task automatic pulse_tick();
        bus.tick = 1'b1;
        cycle();
        bus.tick = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
    endtask

    initial begin
        bus.KEY   = 4'hF;
        bus.tick  = 1'b0;
        bus.clear = 1'b0;

        phase = "reset";
        cycles(3);
        rst_n = 1'b1;
        cycles(50);

        phase = "single_press";
        press_key(0, 10);
        pulse_tick();
        cycles(3);

        phase = "bounce";
        pulse_clear();
        for (int i = 0; i < 10; i++) begin
            bus.KEY[2] = ~bus.KEY[2];
            cycles(2);
        end
        bus.KEY[2] = 1'b1;
        cycles(10);

        phase = "illegal";
        press_key(2, 10);
        press_key(1, 10);

        phase = "queue";
        press_key(0, 10);
        press_key(2, 10);
        press_key(3, 10);
        pulse_tick();
        cycles(2);
        pulse_tick();
        cycles(2);

        phase = "simultaneous";
        pulse_clear();
        bus.KEY = 4'b0010;
        cycles(10);
        bus.KEY = 4'hF;
        cycles(8);

        phase = "tick_push_full";
        pulse_clear();
        press_key(0, 10);
        press_key(2, 10);
        bus.KEY[3] = 1'b0;
        cycles(5);
        pulse_tick();
        cycles(4);
        bus.KEY[3] = 1'b1;
        cycles(8);

        phase = "clear_full";
        press_key(1, 10);
        pulse_clear();
        cycles(2);

        phase = "reset_mid_debounce";
        bus.KEY[0] = 1'b0;
        cycles(3);
        rst_n = 1'b0;
        cycle();
        bus.KEY[0] = 1'b1;
        rst_n = 1'b1;
        cycles(12);

        phase = "random";
        for (int n = 0; n < 60; n++) begin
            int k, hold, gap;
            k    = $urandom_range(0, 3);
            hold = $urandom_range(1, 9);
            bus.KEY[k] = 1'b0;
            if ($urandom_range(0, 3) == 0) bus.KEY[$urandom_range(0, 3)] = 1'b0;
            for (int i = 0; i < hold; i++) begin
                bus.tick  = ($urandom_range(0, 7) == 0);
                bus.clear = ($urandom_range(0, 40) == 0);
                cycle();
            end
            bus.KEY   = 4'hF;
            bus.clear = 1'b0;
            gap = $urandom_range(4, 10);
            for (int i = 0; i < gap; i++) begin
                bus.tick = ($urandom_range(0, 5) == 0);
                cycle();
            end
            bus.tick = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
